// File: rtl/colour_cmd_parser_pkg.sv
// Shared constants and helpers for the UART colour command parser:
// ASCII command characters, FSM/channel encodings and hex decoding.
package colour_cmd_pkg;

   localparam logic [7:0] CH_R         = 8'h72;
   localparam logic [7:0] CH_R_UC      = 8'h52;
   localparam logic [7:0] CH_G         = 8'h67;
   localparam logic [7:0] CH_G_UC      = 8'h47;
   localparam logic [7:0] CH_B         = 8'h62;
   localparam logic [7:0] CH_B_UC      = 8'h42;
   localparam logic [7:0] WS_CR        = 8'h0D;
   localparam logic [7:0] WS_LF        = 8'h0A;
   localparam logic [7:0] WS_SP        = 8'h20;
   localparam logic [7:0] CMD_DEFAULTS = 8'h21;
   localparam logic [7:0] ALIAS_W      = 8'h77;
   localparam logic [7:0] ALIAS_W_UC   = 8'h57;
   localparam logic [7:0] ALIAS_B      = 8'h62;
   localparam logic [7:0] ALIAS_B_UC   = 8'h42;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_DIGITS_ENC = 2'd1;
   localparam logic [1:0] ST_SLOT_ENC   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_DIGITS = ST_DIGITS_ENC,
      ST_SLOT   = ST_SLOT_ENC
   } state_t;

   localparam logic [1:0] CHAN_R    = 2'b00;
   localparam logic [1:0] CHAN_G    = 2'b01;
   localparam logic [1:0] CHAN_B    = 2'b10;
   localparam logic [1:0] CHAN_IDLE = 2'b11;

   // Returns {valid, nibble}; letters A-F / a-f share the same low bits.
   function automatic logic [4:0] ascii_hex_nibble(input logic [7:0] b);
      logic [4:0] result;
      result = 5'b0;
      if (b >= 8'h30 && b <= 8'h39) begin
         result = {1'b1, b[3:0]};
      end else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
         result = {1'b1, b[3:0] + 4'd9};
      end
      return result;
   endfunction

endpackage

// File: rtl/colour_cmd_parser_if.sv
// UART receive byte stream as seen by the colour command parser.
interface colour_cmd_parser_if;
   logic [7:0] uart_data;
   logic       uart_data_valid;

   modport master (output uart_data, output uart_data_valid);
   modport slave  (input  uart_data, input  uart_data_valid);
endinterface

// File: rtl/colour_cmd_parser_timeout.sv
// Mid-command inactivity timer: pulses expire when the limit is reached in a
// cycle with no incoming byte. A limit of 0 disables it.
module cmd_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int unsigned CNTW  = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [CNTW-1:0] r_count;
   logic            w_atLimit;

   assign w_atLimit = (r_count == CNTW'(LIMIT));

   always_ff @(posedge clk) begin
      if (reset || clear || !enable || w_atLimit) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expire = (TIMEOUT_CYCLES != 0) && enable && !clear && w_atLimit;

endmodule

// File: rtl/colour_cmd_parser.sv
// UART-driven colour configuration engine: parses "<chan><hex><slot>" commands
// into a bank of RGB slot registers, pulsing cmd_done / cmd_error on completion.
module colour_cmd_parser
   import colour_cmd_pkg::*;
#(
   parameter int unsigned CW             = 4,
   parameter int unsigned NSLOTS         = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter logic [NSLOTS*3*CW-1:0] DEFAULT_COLOURS = {12'h000, 12'h0FF}
) (
   input  logic                     clk,
   input  logic                     reset,
   colour_cmd_parser_if.slave       uart,
   output logic [1:0]               curr_channel,
   output logic [NSLOTS*3*CW-1:0]   slot_colours,
   output logic                     cmd_done,
   output logic                     cmd_error
);

   localparam int unsigned HD   = (CW + 3) / 4;
   localparam int unsigned ACCW = 4 * HD;
   localparam int unsigned DCW  = (HD > 1) ? $clog2(HD) : 1;
   localparam int unsigned OFFW = $clog2(NSLOTS * 3 * CW);
   localparam logic [ACCW-1:0] MAXV = ACCW'((64'd1 << CW) - 1);

   state_t                  r_state;
   logic [1:0]              r_currChannel;
   logic [NSLOTS*3*CW-1:0]  r_slots;
   logic                    r_cmdDone;
   logic                    r_cmdError;
   logic [ACCW-1:0]         r_acc;
   logic [DCW-1:0]          r_digitCount;

   logic            w_byteValid;
   logic [4:0]      w_hex;
   logic            w_slotOk;
   logic [2:0]      w_slotIdx;
   logic            w_slotInRange;
   logic [CW-1:0]   w_satVal;
   logic [OFFW-1:0] w_offset;
   logic            w_expire;
   logic            w_start;
   logic [1:0]      w_startChan;
   logic            w_reload;
   logic            w_digit;
   logic            w_commit;
   logic            w_abort;

   assign w_byteValid = uart.uart_data_valid &&
                        !(uart.uart_data == WS_SP || uart.uart_data == WS_CR ||
                          uart.uart_data == WS_LF);
   assign w_hex = ascii_hex_nibble(uart.uart_data);

   always_comb begin
      w_slotOk  = 1'b0;
      w_slotIdx = 3'd0;
      if (uart.uart_data[7:3] == 5'b00110) begin
         w_slotOk  = 1'b1;
         w_slotIdx = uart.uart_data[2:0];
      end else if (uart.uart_data == ALIAS_W || uart.uart_data == ALIAS_W_UC) begin
         w_slotOk  = 1'b1;
         w_slotIdx = 3'd0;
      end else if (uart.uart_data == ALIAS_B || uart.uart_data == ALIAS_B_UC) begin
         w_slotOk  = 1'b1;
         w_slotIdx = 3'd1;
      end
   end

   assign w_slotInRange = w_slotOk && ({1'b0, w_slotIdx} < 4'(NSLOTS));
   assign w_satVal      = (r_acc > MAXV) ? {CW{1'b1}} : r_acc[CW-1:0];
   assign w_offset      = OFFW'(int'(w_slotIdx) * 3 * CW + int'(r_currChannel) * CW);

   cmd_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (uart.uart_data_valid),
      .enable (r_state != ST_IDLE),
      .expire (w_expire)
   );

   // Decode what the current byte (or a timeout) means in the present state.
   always_comb begin
      w_start     = 1'b0;
      w_startChan = CHAN_IDLE;
      w_reload    = 1'b0;
      w_digit     = 1'b0;
      w_commit    = 1'b0;
      w_abort     = 1'b0;
      if (w_byteValid) begin
         case (r_state)
            ST_IDLE: begin
               case (uart.uart_data)
                  CH_R, CH_R_UC: begin w_start = 1'b1; w_startChan = CHAN_R; end
                  CH_G, CH_G_UC: begin w_start = 1'b1; w_startChan = CHAN_G; end
                  CH_B, CH_B_UC: begin w_start = 1'b1; w_startChan = CHAN_B; end
                  CMD_DEFAULTS:  w_reload = 1'b1;
                  default:       ;
               endcase
            end
            ST_DIGITS: begin
               w_digit = w_hex[4];
               w_abort = !w_hex[4];
            end
            ST_SLOT: begin
               w_commit = w_slotInRange;
               w_abort  = !w_slotInRange;
            end
            default: w_abort = 1'b1;
         endcase
      end else if (w_expire) begin
         w_abort = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_currChannel <= CHAN_IDLE;
         r_slots       <= DEFAULT_COLOURS;
         r_cmdDone     <= 1'b0;
         r_cmdError    <= 1'b0;
         r_acc         <= '0;
         r_digitCount  <= '0;
      end else begin
         r_cmdDone  <= w_commit || w_reload;
         r_cmdError <= w_abort;
         if (w_start) begin
            r_state       <= ST_DIGITS;
            r_currChannel <= w_startChan;
            r_acc         <= '0;
            r_digitCount  <= '0;
         end
         if (w_reload) begin
            r_slots <= DEFAULT_COLOURS;
         end
         if (w_digit) begin
            r_acc <= (r_acc << 4) | ACCW'(w_hex[3:0]);
            if (r_digitCount == DCW'(HD - 1)) begin
               r_state <= ST_SLOT;
            end else begin
               r_digitCount <= r_digitCount + 1'b1;
            end
         end
         if (w_commit) begin
            r_slots[w_offset +: CW] <= w_satVal;
            r_currChannel           <= CHAN_IDLE;
            r_state                 <= ST_IDLE;
         end
         if (w_abort) begin
            r_currChannel <= CHAN_IDLE;
            r_state       <= ST_IDLE;
         end
      end
   end

   assign curr_channel = r_currChannel;
   assign slot_colours = r_slots;
   assign cmd_done     = r_cmdDone;
   assign cmd_error    = r_cmdError;

endmodule

// File: tb/tb_colour_cmd_parser.sv
// Directed self-checking bench for colour_cmd_parser: a CW=4/NSLOTS=2 instance
// with a 100-cycle timeout, plus a CW=8/NSLOTS=3 instance with the timeout disabled.
module tb_colour_cmd_parser;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   colour_cmd_parser_if ifA ();
   colour_cmd_parser_if ifB ();

   logic [1:0]  chanA, chanB;
   logic [23:0] colA;
   logic [71:0] colB;
   logic        doneA, errA, doneB, errB;

   colour_cmd_parser #(
      .CW              (4),
      .NSLOTS          (2),
      .TIMEOUT_CYCLES  (100),
      .DEFAULT_COLOURS (24'h000_0FF)
   ) dutA (
      .clk          (clk),
      .reset        (reset),
      .uart         (ifA),
      .curr_channel (chanA),
      .slot_colours (colA),
      .cmd_done     (doneA),
      .cmd_error    (errA)
   );

   colour_cmd_parser #(
      .CW              (8),
      .NSLOTS          (3),
      .TIMEOUT_CYCLES  (0),
      .DEFAULT_COLOURS (72'h0)
   ) dutB (
      .clk          (clk),
      .reset        (reset),
      .uart         (ifB),
      .curr_channel (chanB),
      .slot_colours (colB),
      .cmd_done     (doneB),
      .cmd_error    (errB)
   );

   // Presents one byte for one cycle, returning 1ns after the sampling edge.
   task automatic applyStimulus(input bit toB, input logic [7:0] b);
      @(negedge clk);
      if (toB) begin
         ifB.uart_data       = b;
         ifB.uart_data_valid = 1'b1;
      end else begin
         ifA.uart_data       = b;
         ifA.uart_data_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      ifA.uart_data_valid = 1'b0;
      ifB.uart_data_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [71:0] observed,
                              input logic [71:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkA(input string tag, input logic [23:0] col, input logic [1:0] ch,
                         input logic done, input logic err);
      checkOutput({tag, ".colours"}, 72'(colA), 72'(col));
      checkOutput({tag, ".channel"}, 72'(chanA), 72'(ch));
      checkOutput({tag, ".done"}, 72'(doneA), 72'(done));
      checkOutput({tag, ".error"}, 72'(errA), 72'(err));
   endtask

   initial begin
      ifA.uart_data = 8'h00; ifA.uart_data_valid = 1'b0;
      ifB.uart_data = 8'h00; ifB.uart_data_valid = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset defaults");
      checkA("reset", 24'h000_0FF, 2'b11, 1'b0, 1'b0);
      checkOutput("resetB.colours", colB, 72'h0);
      checkOutput("resetB.channel", 72'(chanB), 72'h3);

      $display("[TB] basic command r A b");
      applyStimulus(1'b0, "r");
      checkOutput("rAb.chanAfterR", 72'(chanA), 72'h0);
      applyStimulus(1'b0, "A");
      checkA("rAb.afterDigit", 24'h000_0FF, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, "b");
      checkA("rAb.commit", 24'h00A_0FF, 2'b11, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("rAb.donePulseEnds", 72'(doneA), 72'h0);

      $display("[TB] bad digit g Z");
      applyStimulus(1'b0, "g");
      applyStimulus(1'b0, "Z");
      checkA("gZ.abort", 24'h00A_0FF, 2'b11, 1'b0, 1'b1);
      idleCycles(1);
      checkOutput("gZ.errPulseEnds", 72'(errA), 72'h0);

      $display("[TB] out of range slot b 5 7");
      applyStimulus(1'b0, "b");
      applyStimulus(1'b0, "5");
      applyStimulus(1'b0, "7");
      checkA("b57.abort", 24'h00A_0FF, 2'b11, 1'b0, 1'b1);

      $display("[TB] uppercase blue to slot0");
      applyStimulus(1'b0, "B");
      applyStimulus(1'b0, "F");
      applyStimulus(1'b0, "0");
      checkA("BF0.commit", 24'h00A_FFF, 2'b11, 1'b1, 1'b0);

      $display("[TB] whitespace inside command");
      applyStimulus(1'b0, "G");
      applyStimulus(1'b0, " ");
      checkOutput("ws.chanHeld", 72'(chanA), 72'h1);
      applyStimulus(1'b0, "3");
      applyStimulus(1'b0, 8'h0D);
      checkOutput("ws.noPulse", 72'(errA | doneA), 72'h0);
      applyStimulus(1'b0, "1");
      checkA("ws.commit", 24'h03A_FFF, 2'b11, 1'b1, 1'b0);

      $display("[TB] unknown idle byte and invalid slot byte");
      applyStimulus(1'b0, "x");
      checkA("idleX.ignored", 24'h03A_FFF, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, "r");
      applyStimulus(1'b0, "F");
      applyStimulus(1'b0, "9");
      checkA("rF9.abort", 24'h03A_FFF, 2'b11, 1'b0, 1'b1);

      $display("[TB] lowercase hex with W alias");
      applyStimulus(1'b0, "R");
      applyStimulus(1'b0, "c");
      applyStimulus(1'b0, "W");
      checkA("RcW.commit", 24'h03A_FFC, 2'b11, 1'b1, 1'b0);

      $display("[TB] timeout expiry");
      applyStimulus(1'b0, "r");
      repeat (99) @(posedge clk);
      #1;
      checkOutput("timeout.notYet", 72'(errA), 72'h0);
      checkOutput("timeout.stillEditing", 72'(chanA), 72'h0);
      idleCycles(1);
      checkA("timeout.abort", 24'h03A_FFC, 2'b11, 1'b0, 1'b1);
      idleCycles(1);
      checkOutput("timeout.onceOnly", 72'(errA), 72'h0);

      $display("[TB] byte on last cycle beats timeout");
      applyStimulus(1'b0, "r");
      repeat (99) @(posedge clk);
      applyStimulus(1'b0, "5");
      checkOutput("lastCycle.noError", 72'(errA), 72'h0);
      checkOutput("lastCycle.stillEditing", 72'(chanA), 72'h0);
      applyStimulus(1'b0, "w");
      checkA("lastCycle.commit", 24'h03A_FF5, 2'b11, 1'b1, 1'b0);

      $display("[TB] reset mid command");
      applyStimulus(1'b0, "b");
      applyStimulus(1'b0, "F");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkA("midReset", 24'h000_0FF, 2'b11, 1'b0, 1'b0);
      idleCycles(1);
      checkA("midReset.quiet", 24'h000_0FF, 2'b11, 1'b0, 1'b0);

      $display("[TB] reload defaults");
      applyStimulus(1'b0, "g");
      applyStimulus(1'b0, "7");
      applyStimulus(1'b0, "1");
      checkA("g71.commit", 24'h070_0FF, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, "!");
      checkA("reload", 24'h000_0FF, 2'b11, 1'b1, 1'b0);
      idleCycles(1);
      checkOutput("reload.donePulseEnds", 72'(doneA), 72'h0);

      $display("[TB] wide instance G 3 C space 2");
      applyStimulus(1'b1, "G");
      checkOutput("wide.chanG", 72'(chanB), 72'h1);
      applyStimulus(1'b1, "3");
      applyStimulus(1'b1, "C");
      applyStimulus(1'b1, " ");
      checkOutput("wide.chanBeforeSlot", 72'(chanB), 72'h1);
      checkOutput("wide.noDoneYet", 72'(doneB), 72'h0);
      applyStimulus(1'b1, "2");
      checkOutput("wide.colours", colB, 72'h003C00_000000_000000);
      checkOutput("wide.done", 72'(doneB), 72'h1);
      checkOutput("wide.chanIdle", 72'(chanB), 72'h3);

      $display("[TB] wide instance slot 3 out of range");
      applyStimulus(1'b1, "r");
      applyStimulus(1'b1, "1");
      applyStimulus(1'b1, "2");
      applyStimulus(1'b1, "3");
      checkOutput("wideR123.error", 72'(errB), 72'h1);
      checkOutput("wideR123.colours", colB, 72'h003C00_000000_000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
